// File: rtl/gpu_clk_pkg.sv
// gpu_clk_pkg: shared state encoding and default cycle constants for the GPU clock/reset blocks
package gpu_clk_pkg;
  typedef enum logic [1:0] {PLL_RESET, WAIT_LOCK, STABILIZE, RUN} pll_rst_state_e;
  localparam int unsigned RETRY_W = 8;
  localparam int unsigned DEF_RST_PULSE_CYCLES = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_CNT_W = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchroniser, reset value 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[0], d};
  always_ff @(posedge clk)
    if (rst) ff_q <= '0;
    else ff_q <= ff_d;
  assign q = ff_q[1];
endmodule

// File: rtl/gpu_pll_reset_ctrl.sv
// gpu_pll_reset_ctrl: PLL reset sequencer releasing GPU sys_rst after stable lock; GPU_PLL_LOCK_LOSS_CNT_EN adds lock_loss_count
module gpu_pll_reset_ctrl
  import gpu_clk_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic pll_rst,
  output logic sys_rst,
  output logic ready,
  output logic lock_lost,
  output logic [RETRY_W-1:0] retry_count
`ifdef GPU_PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [15:0] lock_loss_count
`endif
);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  pll_rst_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic pll_rst_q, pll_rst_d, sys_rst_q, sys_rst_d, ready_q, ready_d, lock_lost_q, lock_lost_d;
  logic lock_s, timeout;
  sync_2ff u_sync (
    .clk(clk),
    .rst(rst),
    .d(pll_locked),
    .q(lock_s)
  );
  always_comb begin
    timeout = state_q == WAIT_LOCK && !lock_s && cnt_q == TIMEOUT_LAST;
    state_d = state_q == PLL_RESET ? (cnt_q == RST_LAST ? WAIT_LOCK : PLL_RESET)
            : state_q == WAIT_LOCK ? (lock_s ? STABILIZE : timeout ? PLL_RESET : WAIT_LOCK)
            : state_q == STABILIZE ? (!lock_s ? WAIT_LOCK : cnt_q == STABLE_LAST ? RUN : STABILIZE)
            : (lock_s ? RUN : PLL_RESET);
    cnt_d = state_d != state_q ? '0 : cnt_q + 1'b1;
    pll_rst_d = state_d == PLL_RESET;
    sys_rst_d = state_d != RUN;
    ready_d = state_d == RUN;
    lock_lost_d = state_q == RUN && !lock_s;
    retry_d = timeout && retry_q != '1 ? retry_q + 1'b1 : retry_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= PLL_RESET;
      cnt_q <= '0;
      retry_q <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      retry_q <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  assign pll_rst = pll_rst_q;
  assign sys_rst = sys_rst_q;
  assign ready = ready_q;
  assign lock_lost = lock_lost_q;
  assign retry_count = retry_q;
`ifdef GPU_PLL_LOCK_LOSS_CNT_EN
  logic [15:0] llc_q, llc_d;
  always_comb llc_d = lock_lost_d && llc_q != '1 ? llc_q + 1'b1 : llc_q;
  always_ff @(posedge clk)
    if (rst) llc_q <= '0;
    else llc_q <= llc_d;
  assign lock_loss_count = llc_q;
`endif
endmodule
